// File: rtl/alu_operand_sequencer.sv
// Operand-entry stage in front of the calculator ALU: collects A, B and OP on
// successive enter presses, latches the ALU result and supports chaining and undo.
module alu_operand_sequencer #(
    parameter int largo = 16
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [largo-1:0] data_in,
    input  logic             enter,
    input  logic             undo,
    input  logic [largo-1:0] alu_result,
    output logic [largo-1:0] A,
    output logic [largo-1:0] B,
    output logic [2:0]       OP,
    output logic [largo-1:0] display,
    output logic [2:0]       state,
    output logic             result_valid,
    output logic             op_error
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        CALC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    state_t           state_r;
    logic             enter_prev_r;
    logic             undo_prev_r;
    logic [largo-1:0] a_r;
    logic [largo-1:0] b_r;
    logic [2:0]       op_r;
    logic [largo-1:0] result_r;
    logic             result_valid_r;
    logic             op_error_r;

    logic             enter_rise_s;
    logic             undo_rise_s;
    logic             enter_go_s;
    logic             undo_go_s;

    // Accepted ALU op codes are 0, 1, 2, 4 and 5.
    function automatic logic op_is_valid(input logic [2:0] op);
        case (op)
            3'd0, 3'd1, 3'd2, 3'd4, 3'd5: op_is_valid = 1'b1;
            default:                      op_is_valid = 1'b0;
        endcase
    endfunction

    // Rising-edge detect; a press of both buttons together is discarded.
    always_comb begin
        enter_rise_s = enter & ~enter_prev_r;
        undo_rise_s  = undo  & ~undo_prev_r;
        enter_go_s   = enter_rise_s & ~undo_rise_s;
        undo_go_s    = undo_rise_s  & ~enter_rise_s;
    end

    // Sequencer state, operand/result registers and status flags.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_r        <= WAIT_A;
            enter_prev_r   <= 1'b1;
            undo_prev_r    <= 1'b1;
            a_r            <= {largo{1'b0}};
            b_r            <= {largo{1'b0}};
            op_r           <= 3'd0;
            result_r       <= {largo{1'b0}};
            result_valid_r <= 1'b0;
            op_error_r     <= 1'b0;
        end else begin
            enter_prev_r <= enter;
            undo_prev_r  <= undo;
            case (state_r)
                WAIT_A: begin
                    if (enter_go_s) begin
                        a_r     <= data_in;
                        state_r <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (enter_go_s) begin
                        b_r     <= data_in;
                        state_r <= WAIT_OP;
                    end else if (undo_go_s) begin
                        state_r <= WAIT_A;
                    end
                end
                WAIT_OP: begin
                    if (enter_go_s) begin
                        if (op_is_valid(data_in[2:0])) begin
                            op_r       <= data_in[2:0];
                            op_error_r <= 1'b0;
                            state_r    <= CALC;
                        end else begin
                            op_error_r <= 1'b1;
                        end
                    end else if (undo_go_s) begin
                        op_error_r <= 1'b0;
                        state_r    <= WAIT_B;
                    end
                end
                // Operands have been stable for a full cycle; capture the ALU output.
                CALC: begin
                    result_r       <= alu_result;
                    result_valid_r <= 1'b1;
                    state_r        <= SHOW;
                end
                SHOW: begin
                    if (enter_go_s) begin
                        a_r            <= result_r;
                        result_valid_r <= 1'b0;
                        state_r        <= WAIT_B;
                    end else if (undo_go_s) begin
                        result_valid_r <= 1'b0;
                        state_r        <= WAIT_OP;
                    end
                end
                default: begin
                    state_r        <= WAIT_A;
                    result_valid_r <= 1'b0;
                    op_error_r     <= 1'b0;
                end
            endcase
        end
    end

    assign A            = a_r;
    assign B            = b_r;
    assign OP           = op_r;
    assign state        = state_r;
    assign result_valid = result_valid_r;
    assign op_error     = op_error_r;
    // Switches are echoed live except while a result is being shown.
    assign display      = result_valid_r ? result_r : data_in;

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Operand-entry stage placed directly upstream of the ALU in the calculator datapath. It captures operand A, operand B and the 3-bit operation code from the board switches on successive debounced `enter` presses, and drives them as registered values into the ALU. It latches the ALU result and presents it on a display bus. A shown result can be chained as the next A operand, and an `undo` press steps back one entry.

## Interface
- `largo`, 16, operand and result width in bits; must match the ALU's `largo`.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `resetN`  in  1  synchronous, active-low reset.
- `data_in`  in  largo  switch value; operand source, and `data_in[2:0]` is the op source.
- `enter`  in  1  debounced level; a rising edge advances the sequence.
- `undo`  in  1  debounced level; a rising edge steps back one state.
- `alu_result`  in  largo  combinational result from the ALU.
- `A`  out  largo  registered operand A to the ALU.
- `B`  out  largo  registered operand B to the ALU.
- `OP`  out  3  registered operation code to the ALU.
- `display`  out  largo  value for the 7-segment driver.
- `state`  out  3  current state code, for the LEDs.
- `result_valid`  out  1  high while in SHOW.
- `op_error`  out  1  high after an invalid op code is entered.

## Operation
- **Edge detection.** `enter` and `undo` each have a one-register previous-sample flop. A rising edge is current=1 and previous=0. The previous-sample flops reset to 1, so a button held through reset release does not fire.
- **Simultaneous edges.** If both edges occur in the same cycle, neither acts.
- **State codes.** WAIT_A=0, WAIT_B=1, WAIT_OP=2, CALC=3, SHOW=4. The `state` output carries this code.
- **Reset values.** state=WAIT_A. A=0, B=0, OP=0. The result register is 0. result_valid=0, op_error=0.
- **WAIT_A**
  - `enter`: A ← data_in, go to WAIT_B.
  - `undo`: ignored.
- **WAIT_B**
  - `enter`: B ← data_in, go to WAIT_OP.
  - `undo`: go to WAIT_A (A is kept).
- **WAIT_OP**
  - `enter` with data_in[2:0] ∈ {0,1,2,4,5}: OP ← data_in[2:0], op_error ← 0, go to CALC.
  - `enter` with data_in[2:0] ∈ {3,6,7}: OP is unchanged, op_error ← 1, stay in WAIT_OP.
  - `undo`: op_error ← 0, go to WAIT_B.
- **CALC** (one cycle, unconditional)
  - A, B and OP are stable, so the combinational ALU output is valid.
  - The result register ← alu_result at the end of the cycle. Go to SHOW.
  - Edges arriving in CALC are ignored and not queued.
- **SHOW**
  - `enter`: A ← result register (chaining), go to WAIT_B.
  - `undo`: go to WAIT_OP (op_error stays 0).
- **Display.** `display` = result register in SHOW; `data_in` in all other states.
- **Width.** The result is stored exactly as the ALU produces it, already `largo` bits with any overflow truncated. No sign handling in this block.
- **Reset mid-sequence.** A synchronous `resetN`=0 in any state forces all reset values at the next clock edge. Reset has priority over any edge arriving in the same cycle.

## Timing
- **Edge in cycle n.** The state and register updates take effect at the clock edge ending cycle n and are visible in cycle n+1.
- **Valid-op latency.** A valid-op `enter` edge in cycle n gives CALC in cycle n+1, and SHOW with result_valid=1 in cycle n+2. The display shows the new result from cycle n+2.
- **result_valid** is a registered decode of state==SHOW; it is never high in CALC.
- **op_error** is registered. It sets in the cycle after the invalid entry and holds until a valid op entry, an `undo` from WAIT_OP, or reset.
- **A/B/OP** change only on their load events or reset; they never glitch between loads.
- **Held buttons.** A button held high produces exactly one action per press. Release and re-press are required for the next action.

## Test plan
- **Addition.** Reset, then enter A=5, B=3, op=0. Expect SHOW two cycles after the op edge, display=8, result_valid=1, state=4.
- **Multiply then chain.** A=7, B=6, op=1 gives display=42. Press `enter` in SHOW: A=42, state=1. Enter B=2, op=4: display=40.
- **Invalid op.** In WAIT_OP enter op=3: op_error=1, state stays 2, OP unchanged. Then enter op=5: op_error=0, go to CALC.
- **Undo walk.** From SHOW press `undo` three times: states 2, 1, 0. A and B keep their values. A further `undo` in WAIT_A changes nothing.
- **Reset mid-sequence.** In WAIT_OP with A=9, B=4, pulse resetN=0 for one cycle. Expect state=0, A=B=OP=0, display=data_in, result_valid=0.
- **Held and simultaneous edges.**
  - Hold `enter` high through reset release: no transition.
  - Raise `enter` and `undo` in the same cycle: no transition.
  - Hold `enter` for 10 cycles: exactly one transition.
